hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's forwarding block for the 5-stage (F/D/E/M/W) core.
- Tracks destination registers in flight through E/M/W in its own shadow slots, so decode only presents the instruction once.
- Generates forwarding selects for N source operands, D-stage write-back bypass, load-use stalls of configurable length, and branch flushes.
- Sits beside the stage modules at pipeline top; drives their stall/flush/forward inputs.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_match.sv | 19 +
 rtl/hazard_scoreboard.sv | 150 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: shadow-slot record, forward-select encoding, limits.
package hazard_pkg;

   localparam int MAX_SRC = 4;
   localparam int MAX_AW  = 8;

   typedef struct packed {
      logic              valid;
      logic [MAX_AW-1:0] rd;
      logic              we;
      logic              ld;
   } slot_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one shadow slot's destination against one source address; register 0 never
// matches when ZERO_REG is set.
module hazard_match #(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              valid_i,
   input  logic              we_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic [REG_AW-1:0] addr_i,
   output logic              hit_o
);

   logic is_zero;

   assign is_zero = (ZERO_REG != 0) && (addr_i == '0);
   assign hit_o   = valid_i && we_i && (rd_i == addr_i) && !is_zero;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage core: shadow E/M/W slots, forwarding selects, load-use
// stalls and branch flushes. Define HAZARD_PERF_EN to build the stall/flush event counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_SRC  = 3,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_d,
   input  logic [NUM_SRC*REG_AW-1:0] rs_d,
   input  logic [NUM_SRC-1:0]        rs_used_d,
   input  logic [REG_AW-1:0]         rd_d,
   input  logic                      reg_write_d,
   input  logic                      is_load_d,
   input  logic                      branch_taken_e,
   output logic [2*NUM_SRC-1:0]      fwd_sel_e,
   output logic [NUM_SRC-1:0]        fwd_d,
   output logic                      stall_f,
   output logic                      stall_d,
   output logic                      flush_d,
   output logic                      flush_e,
   output logic [15:0]               stall_cnt,
   output logic [15:0]               flush_cnt
);

   slot_t                      slot_e_q, slot_m_q, slot_w_q;
   slot_t                      slot_e_d;
   logic [NUM_SRC*REG_AW-1:0]  rs_e_q, rs_e_d;
   logic [NUM_SRC-1:0]         rs_used_e_q, rs_used_e_d;

   logic [NUM_SRC-1:0]         hit_ed, hit_md, hit_wd;
   logic [NUM_SRC-1:0]         hit_me, hit_we;
   logic                       load_use;
   logic                       stall_act;
   logic                       unused_slot_bits;

   // D operands against E/M/W, E operands against M/W
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hazard_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_ed (
         .valid_i(slot_e_q.valid), .we_i(slot_e_q.we), .rd_i(slot_e_q.rd[REG_AW-1:0]),
         .addr_i(rs_d[i*REG_AW +: REG_AW]), .hit_o(hit_ed[i]));
      hazard_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_md (
         .valid_i(slot_m_q.valid), .we_i(slot_m_q.we), .rd_i(slot_m_q.rd[REG_AW-1:0]),
         .addr_i(rs_d[i*REG_AW +: REG_AW]), .hit_o(hit_md[i]));
      hazard_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_wd (
         .valid_i(slot_w_q.valid), .we_i(slot_w_q.we), .rd_i(slot_w_q.rd[REG_AW-1:0]),
         .addr_i(rs_d[i*REG_AW +: REG_AW]), .hit_o(hit_wd[i]));
      hazard_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_me (
         .valid_i(slot_m_q.valid), .we_i(slot_m_q.we), .rd_i(slot_m_q.rd[REG_AW-1:0]),
         .addr_i(rs_e_q[i*REG_AW +: REG_AW]), .hit_o(hit_me[i]));
      hazard_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_we (
         .valid_i(slot_w_q.valid), .we_i(slot_w_q.we), .rd_i(slot_w_q.rd[REG_AW-1:0]),
         .addr_i(rs_e_q[i*REG_AW +: REG_AW]), .hit_o(hit_we[i]));

      assign fwd_d[i] = rs_used_d[i] && hit_wd[i];
   end

   always_comb begin
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (rs_used_d[i] && ((hit_ed[i] && slot_e_q.ld) ||
                              ((LOAD_LAT == 2) && hit_md[i] && slot_m_q.ld))) begin
            load_use = 1'b1;
         end
      end
      load_use = load_use && valid_d;
   end

   // A taken branch kills D anyway, so it overrides the load-use stall.
   assign stall_act = load_use && !branch_taken_e;
   assign stall_f   = stall_act;
   assign stall_d   = stall_act;
   assign flush_d   = branch_taken_e;
   assign flush_e   = branch_taken_e || load_use;

   always_comb begin
      fwd_sel_e = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (rs_used_e_q[i] && hit_me[i] && !slot_m_q.ld) begin
            fwd_sel_e[2*i +: 2] = FWD_M;
         end else if (rs_used_e_q[i] && hit_we[i]) begin
            fwd_sel_e[2*i +: 2] = FWD_W;
         end else begin
            fwd_sel_e[2*i +: 2] = FWD_RF;
         end
      end
   end

   always_comb begin
      slot_e_d    = '0;
      rs_e_d      = '0;
      rs_used_e_d = '0;
      if (!flush_e) begin
         slot_e_d.valid = valid_d;
         slot_e_d.rd    = MAX_AW'(rd_d);
         slot_e_d.we    = reg_write_d;
         slot_e_d.ld    = is_load_d;
         rs_e_d         = rs_d;
         rs_used_e_d    = rs_used_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_e_q    <= '0;
         slot_m_q    <= '0;
         slot_w_q    <= '0;
         rs_e_q      <= '0;
         rs_used_e_q <= '0;
      end else begin
         slot_w_q    <= slot_m_q;
         slot_m_q    <= slot_e_q;
         slot_e_q    <= slot_e_d;
         rs_e_q      <= rs_e_d;
         rs_used_e_q <= rs_used_e_d;
      end
   end

   // W.ld and the rd padding above REG_AW have no consumer.
   assign unused_slot_bits = ^{slot_e_q, slot_m_q, slot_w_q};

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_act && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (branch_taken_e && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_LAT=1/ZERO_REG=1 and LOAD_LAT=2/ZERO_REG=0)
// share stimulus and are checked every cycle against an in-flight instruction history model.
module tb_hazard_scoreboard;

`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_d;
   logic [14:0] rs_d;
   logic [2:0]  rs_used_d;
   logic [4:0]  rd_d;
   logic        reg_write_d;
   logic        is_load_d;
   logic        branch_taken_e;

   logic [5:0]  fs0, fs1;
   logic [2:0]  fwd0, fwd1;
   logic        sf0, sf1, sd0, sd1, fd0, fd1, fe0, fe1;
   logic [15:0] sc0, sc1, fc0, fc1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NUM_SRC(3), .REG_AW(5), .LOAD_LAT(1), .ZERO_REG(1)) dut0 (
      .clk(clk), .rst(rst), .valid_d(valid_d), .rs_d(rs_d), .rs_used_d(rs_used_d),
      .rd_d(rd_d), .reg_write_d(reg_write_d), .is_load_d(is_load_d),
      .branch_taken_e(branch_taken_e), .fwd_sel_e(fs0), .fwd_d(fwd0),
      .stall_f(sf0), .stall_d(sd0), .flush_d(fd0), .flush_e(fe0),
      .stall_cnt(sc0), .flush_cnt(fc0));

   hazard_scoreboard #(.NUM_SRC(3), .REG_AW(5), .LOAD_LAT(2), .ZERO_REG(0)) dut1 (
      .clk(clk), .rst(rst), .valid_d(valid_d), .rs_d(rs_d), .rs_used_d(rs_used_d),
      .rd_d(rd_d), .reg_write_d(reg_write_d), .is_load_d(is_load_d),
      .branch_taken_e(branch_taken_e), .fwd_sel_e(fs1), .fwd_d(fwd1),
      .stall_f(sf1), .stall_d(sd1), .flush_d(fd1), .flush_e(fe1),
      .stall_cnt(sc1), .flush_cnt(fc1));

   // An instruction as it travels down the pipe; hist[k][n] is the one that entered E n+1 clocks ago.
   typedef struct packed {
      logic        v;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic [14:0] rs;
      logic [2:0]  used;
   } ins_t;

   ins_t hist [2][3];
   int   n_stall [2];
   int   n_flush [2];

   function automatic int ll(int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic bit zr(int k);
      return (k == 0);
   endfunction

   function automatic bit mt(ins_t s, logic [4:0] r, bit z);
      return s.v && s.we && (s.rd == r) && !(z && (r == 5'd0));
   endfunction

   function automatic bit haz(int k);
      bit h;
      logic [4:0] r;
      h = 1'b0;
      for (int i = 0; i < 3; i++) begin
         r = rs_d[i*5 +: 5];
         if (rs_used_d[i]) begin
            if (mt(hist[k][0], r, zr(k)) && hist[k][0].ld) h = 1'b1;
            if (ll(k) == 2 && mt(hist[k][1], r, zr(k)) && hist[k][1].ld) h = 1'b1;
         end
      end
      return h && valid_d;
   endfunction

   function automatic logic [5:0] exp_fsel(int k);
      logic [5:0] f;
      logic [4:0] r;
      ins_t e, m, w;
      e = hist[k][0]; m = hist[k][1]; w = hist[k][2];
      f = '0;
      for (int i = 0; i < 3; i++) begin
         r = e.rs[i*5 +: 5];
         if (e.used[i] && mt(m, r, zr(k)) && !m.ld)  f[2*i +: 2] = 2'b10;
         else if (e.used[i] && mt(w, r, zr(k)))      f[2*i +: 2] = 2'b01;
      end
      return f;
   endfunction

   function automatic logic [2:0] exp_fwdd(int k);
      logic [2:0] f;
      for (int i = 0; i < 3; i++)
         f[i] = rs_used_d[i] && mt(hist[k][2], rs_d[i*5 +: 5], zr(k));
      return f;
   endfunction

   task automatic compare(string nm, int k, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h, want %0h at %0t", nm, k, act, want, $time);
      end
   endtask

   task automatic check_all();
      bit h, br;
      for (int k = 0; k < 2; k++) begin
         h  = haz(k);
         br = branch_taken_e;
         compare("stall_f",   k, k ? sf1 : sf0,   h && !br);
         compare("stall_d",   k, k ? sd1 : sd0,   h && !br);
         compare("flush_d",   k, k ? fd1 : fd0,   br);
         compare("flush_e",   k, k ? fe1 : fe0,   h || br);
         compare("fwd_sel_e", k, k ? fs1 : fs0,   exp_fsel(k));
         compare("fwd_d",     k, k ? fwd1 : fwd0, exp_fwdd(k));
         compare("stall_cnt", k, k ? sc1 : sc0,   PERF ? n_stall[k] : 0);
         compare("flush_cnt", k, k ? fc1 : fc0,   PERF ? n_flush[k] : 0);
      end
   endtask

   task automatic present(bit v, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2, logic [2:0] used,
                          logic [4:0] rd, bit we, bit ld, bit br, bit r);
      @(negedge clk);
      valid_d        = v;
      rs_d           = {r2, r1, r0};
      rs_used_d      = used;
      rd_d           = rd;
      reg_write_d    = we;
      is_load_d      = ld;
      branch_taken_e = br;
      rst            = r;
      #1;
      if (!rst) check_all();
   endtask

   task automatic tick();
      bit h;
      ins_t cur;
      @(posedge clk);
      cur = '{v: valid_d, rd: rd_d, we: reg_write_d, ld: is_load_d, rs: rs_d, used: rs_used_d};
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int n = 0; n < 3; n++) hist[k][n] = '0;
            n_stall[k] = 0;
            n_flush[k] = 0;
         end else begin
            h = haz(k);
            if (h && !branch_taken_e && n_stall[k] < 65535) n_stall[k]++;
            if (branch_taken_e && n_flush[k] < 65535) n_flush[k]++;
            hist[k][2] = hist[k][1];
            hist[k][1] = hist[k][0];
            hist[k][0] = (h || branch_taken_e) ? '0 : cur;
         end
      end
   endtask

   task automatic nop();
      present(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      present(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
      tick();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 3; n++) hist[k][n] = '0;
         n_stall[k] = 0;
         n_flush[k] = 0;
      end

      // Reset state: every output quiet afterwards
      do_reset();
      nop();
      compare("rst_stall_f", 0, sf0, 0);
      compare("rst_fwd_sel", 1, fs1, 0);
      tick();

      // ALU chain through r3: M forward, then W forward
      do_reset();
      present(1, 0, 0, 0, 3'b000, 5'd3, 1, 0, 0, 0); tick();
      present(1, 5'd3, 0, 0, 3'b001, 5'd6, 1, 0, 0, 0); tick();
      present(1, 5'd3, 0, 0, 3'b001, 5'd0, 0, 0, 0, 0);
      compare("alu_fwd_m", 0, fs0[1:0], 2'b10);
      compare("alu_fwd_m", 1, fs1[1:0], 2'b10);
      tick();
      nop();
      compare("alu_fwd_w", 0, fs0[1:0], 2'b01);
      tick();

      // Load r5 then an add reading r5
      do_reset();
      present(1, 0, 0, 0, 3'b000, 5'd5, 1, 1, 0, 0); tick();
      present(1, 5'd5, 0, 0, 3'b001, 5'd7, 1, 0, 0, 0);
      compare("ld_stall1", 0, {sf0, sd0, fe0}, 3'b111);
      compare("ld_stall1", 1, {sf1, sd1, fe1}, 3'b111);
      tick();
      present(1, 5'd5, 0, 0, 3'b001, 5'd7, 1, 0, 0, 0);
      compare("ld_stall2", 0, sf0, 0);
      compare("ld_stall2", 1, {sf1, sd1, fe1}, 3'b111);
      tick();
      present(1, 5'd5, 0, 0, 3'b001, 5'd7, 1, 0, 0, 0);
      compare("ld_after_fsel", 0, fs0[1:0], 2'b01);
      compare("ld_after_fsel", 1, fs1[1:0], 2'b00);
      compare("ld_after_fwdd", 1, fwd1[0], 1);
      compare("ld_after_stall", 1, sf1, 0);
      compare("ld_stall_cnt", 0, sc0, PERF ? 1 : 0);
      compare("ld_stall_cnt", 1, sc1, PERF ? 2 : 0);
      tick();

      // Branch with a simultaneous load-use hazard
      do_reset();
      present(1, 0, 0, 0, 3'b000, 5'd5, 1, 1, 0, 0); tick();
      present(1, 5'd5, 0, 0, 3'b001, 5'd7, 1, 0, 1, 0);
      compare("br_flush", 0, {fd0, fe0, sf0, sd0}, 4'b1100);
      compare("br_flush", 1, {fd1, fe1, sf1, sd1}, 4'b1100);
      tick();
      nop();
      compare("br_no_stall", 0, sf0, 0);
      compare("br_flush_cnt", 0, fc0, PERF ? 1 : 0);
      compare("br_stall_cnt", 0, sc0, 0);
      tick();

      // Register 0 writes and loads
      do_reset();
      present(1, 0, 0, 0, 3'b000, 5'd0, 1, 0, 0, 0); tick();
      present(1, 5'd0, 0, 0, 3'b001, 5'd9, 1, 0, 0, 0); tick();
      nop();
      compare("r0_fsel", 0, fs0[1:0], 2'b00);
      compare("r0_fsel", 1, fs1[1:0], 2'b10);
      tick();
      do_reset();
      present(1, 0, 0, 0, 3'b000, 5'd0, 1, 1, 0, 0); tick();
      present(1, 5'd0, 0, 0, 3'b001, 5'd9, 1, 0, 0, 0);
      compare("r0_ld_stall", 0, sf0, 0);
      compare("r0_ld_stall", 1, sf1, 1);
      tick();

      // Reset in the middle of a two-cycle load stall
      do_reset();
      present(1, 0, 0, 0, 3'b000, 5'd5, 1, 1, 0, 0); tick();
      present(1, 5'd5, 0, 0, 3'b001, 5'd7, 1, 0, 0, 0); tick();
      present(1, 5'd5, 0, 0, 3'b001, 5'd7, 1, 0, 0, 1); tick();
      present(1, 5'd5, 0, 0, 3'b001, 5'd7, 1, 0, 0, 0);
      compare("rst_mid_ctl", 1, {sf1, sd1, fd1, fe1}, 4'b0000);
      compare("rst_mid_fsel", 1, fs1, 0);
      compare("rst_mid_fwdd", 1, fwd1, 0);
      compare("rst_mid_cnt", 1, sc1, 0);
      tick();

      // Randomized traffic on a small register window to provoke hazards
      for (int c = 0; c < 2000; c++) begin
         present($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
